// File: rtl/score_text_ctrl.sv
// Score text controller: owns the 16x16 character buffer read by the drawing stage and
// rewrites the two two-digit scores (or blanks the whole buffer) only while vblnk is high.
module score_text_ctrl #(
    parameter int unsigned SCORE_ROW  = 0,
    parameter int unsigned LEFT_COL   = 2,
    parameter int unsigned RIGHT_COL  = 12,
    parameter logic [6:0]  BLANK_CODE = 7'h20,
    parameter logic [6:0]  DIGIT_BASE = 7'h30
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       vblnk,
    input  logic [7:0] char_xy,
    output logic [6:0] char_code,
    input  logic       upd_req,
    input  logic [6:0] upd_left,
    input  logic [6:0] upd_right,
    output logic       upd_ack,
    input  logic       clr_req,
    output logic       busy
);

    localparam logic [3:0] ROW    = 4'(SCORE_ROW);
    localparam logic [3:0] LCOL_T = 4'(LEFT_COL);
    localparam logic [3:0] LCOL_U = 4'(LEFT_COL + 1);
    localparam logic [3:0] RCOL_T = 4'(RIGHT_COL);
    localparam logic [3:0] RCOL_U = 4'(RIGHT_COL + 1);

    typedef enum logic [2:0] {
        StInitClr,
        StIdle,
        StClear,
        StConv,
        StWrite,
        StAck
    } state_t;

    state_t     r_state;
    logic       r_init;
    logic [7:0] r_cnt;
    logic [1:0] r_wptr;
    logic [6:0] r_lrem;
    logic [6:0] r_rrem;
    logic [3:0] r_ltens;
    logic [3:0] r_rtens;
    logic       r_ack;
    logic       r_busy;
    logic [6:0] r_code;
    logic [6:0] r_mem [256];

    logic [6:0] w_left_sat;
    logic [6:0] w_right_sat;
    logic       w_l_ge;
    logic       w_r_ge;
    logic [6:0] w_lrem_sub;
    logic [6:0] w_rrem_sub;
    logic       w_conv_done;
    logic       w_we;
    logic [7:0] w_waddr;
    logic [6:0] w_wdata;

    assign w_left_sat  = (upd_left > 7'd99) ? 7'd99 : upd_left;
    assign w_right_sat = (upd_right > 7'd99) ? 7'd99 : upd_right;

    // One subtraction per cycle: left first, then right once left is below ten.
    assign w_l_ge      = (r_lrem >= 7'd10);
    assign w_r_ge      = (r_rrem >= 7'd10);
    assign w_lrem_sub  = r_lrem - 7'd10;
    assign w_rrem_sub  = r_rrem - 7'd10;
    assign w_conv_done = w_l_ge ? ((w_lrem_sub < 7'd10) && !w_r_ge)
                       : (w_r_ge ? (w_rrem_sub < 7'd10) : 1'b1);

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_cnt;
        w_wdata = BLANK_CODE;
        if (!rst && vblnk) begin
            if (r_state == StClear) begin
                w_we = 1'b1;
            end else if (r_state == StWrite) begin
                w_we = 1'b1;
                unique case (r_wptr)
                    2'd0: begin
                        w_waddr = {ROW, LCOL_T};
                        w_wdata = (r_ltens == 4'd0) ? BLANK_CODE : DIGIT_BASE + 7'(r_ltens);
                    end
                    2'd1: begin
                        w_waddr = {ROW, LCOL_U};
                        w_wdata = DIGIT_BASE + r_lrem;
                    end
                    2'd2: begin
                        w_waddr = {ROW, RCOL_T};
                        w_wdata = (r_rtens == 4'd0) ? BLANK_CODE : DIGIT_BASE + 7'(r_rtens);
                    end
                    2'd3: begin
                        w_waddr = {ROW, RCOL_U};
                        w_wdata = DIGIT_BASE + r_rrem;
                    end
                    default: begin
                        w_waddr = r_cnt;
                        w_wdata = BLANK_CODE;
                    end
                endcase
            end
        end
    end

    // Buffer contents are deliberately not reset; INIT_CLR rewrites every cell.
    always_ff @(posedge pclk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Read-before-write: a same-address collision returns the old cell.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_code <= 7'd0;
        end else begin
            r_code <= r_mem[char_xy];
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state <= StInitClr;
            r_init  <= 1'b1;
            r_cnt   <= 8'd0;
            r_wptr  <= 2'd0;
            r_lrem  <= 7'd0;
            r_rrem  <= 7'd0;
            r_ltens <= 4'd0;
            r_rtens <= 4'd0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            r_ack <= 1'b0;
            unique case (r_state)
                StInitClr: begin
                    r_init  <= 1'b1;
                    r_cnt   <= 8'd0;
                    r_state <= StClear;
                end
                StIdle: begin
                    if (clr_req) begin
                        r_cnt   <= 8'd0;
                        r_busy  <= 1'b1;
                        r_state <= StClear;
                    end else if (upd_req) begin
                        r_lrem  <= w_left_sat;
                        r_rrem  <= w_right_sat;
                        r_ltens <= 4'd0;
                        r_rtens <= 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= StConv;
                    end
                end
                StClear: begin
                    if (vblnk) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == 8'hff) begin
                            // Power-up clear continues into writing the 0:0 scores.
                            if (r_init) begin
                                r_state <= StConv;
                            end else begin
                                r_ack   <= 1'b1;
                                r_state <= StAck;
                            end
                        end
                    end
                end
                StConv: begin
                    if (w_l_ge) begin
                        r_lrem  <= w_lrem_sub;
                        r_ltens <= r_ltens + 4'd1;
                    end else if (w_r_ge) begin
                        r_rrem  <= w_rrem_sub;
                        r_rtens <= r_rtens + 4'd1;
                    end
                    if (w_conv_done) begin
                        r_wptr  <= 2'd0;
                        r_state <= StWrite;
                    end
                end
                StWrite: begin
                    if (vblnk) begin
                        r_wptr <= r_wptr + 2'd1;
                        if (r_wptr == 2'd3) begin
                            if (r_init) begin
                                r_init  <= 1'b0;
                                r_busy  <= 1'b0;
                                r_state <= StIdle;
                            end else begin
                                r_ack   <= 1'b1;
                                r_state <= StAck;
                            end
                        end
                    end
                end
                StAck: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b1;
                    r_state <= StInitClr;
                end
            endcase
        end
    end

    assign char_code = r_code;
    assign upd_ack   = r_ack;
    assign busy      = r_busy;

endmodule
